// File: rtl/npu_pkg.sv
// Shared definitions for the NPU convolution sequencing blocks.
// Holds the scheduler state encoding and the fixed engine geometry limits.
package npu_pkg;

   localparam int K = 3;
   localparam logic [2:0] MAX_STRIDE = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      ISSUE   = 3'd2,
      WAIT    = 3'd3,
      WR1     = 3'd4,
      WR2     = 3'd5,
      ADVANCE = 3'd6,
      DONE    = 3'd7
   } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Row/column walker for the convolution scheduler.
// Source and output addresses are stepped incrementally, no multipliers.
module conv_addr_gen #(
   parameter int IMG_W  = 28,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              init,
   input  logic              advance,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] out_base,
   input  logic [2:0]        stride,
   input  logic [CNT_W-1:0]  out_w,
   input  logic [CNT_W-1:0]  out_h,
   output logic [ADDR_W-1:0] src_addr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              last_pair,
   output logic              odd_tail
);

   logic [CNT_W-1:0]  col;
   logic [CNT_W-1:0]  row;
   logic [ADDR_W-1:0] row_src;
   logic [ADDR_W-1:0] row_step;
   logic [ADDR_W-1:0] col_step;
   logic              row_end;

   always_comb begin
      row_step = '0;
      case (stride)
         3'd1:    row_step = ADDR_W'(IMG_W);
         3'd2:    row_step = ADDR_W'(2 * IMG_W);
         3'd3:    row_step = ADDR_W'(3 * IMG_W);
         3'd4:    row_step = ADDR_W'(4 * IMG_W);
         default: row_step = '0;
      endcase
   end

   assign col_step  = ADDR_W'({stride, 1'b0});
   assign row_end   = ({1'b0, col} + 2) >= {1'b0, out_w};
   assign odd_tail  = ({1'b0, col} + 1) == {1'b0, out_w};
   assign last_pair = row_end && (({1'b0, row} + 1) == {1'b0, out_h});

   // Wrapping a row: the next row's first output sits 1 or 2 past the last pair.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         col      <= '0;
         row      <= '0;
         row_src  <= '0;
         src_addr <= '0;
         out_addr <= '0;
      end else if (init) begin
         col      <= '0;
         row      <= '0;
         row_src  <= src_base;
         src_addr <= src_base;
         out_addr <= out_base;
      end else if (advance) begin
         if (row_end) begin
            col      <= '0;
            row      <= row + CNT_W'(1);
            row_src  <= row_src + row_step;
            src_addr <= row_src + row_step;
            out_addr <= out_addr + (odd_tail ? ADDR_W'(1) : ADDR_W'(2));
         end else begin
            col      <= col + CNT_W'(2);
            src_addr <= src_addr + col_step;
            out_addr <= out_addr + ADDR_W'(2);
         end
      end
   end

endmodule

// File: rtl/conv_scheduler.sv
// Job sequencer for the dual-window 3x3 convolution engine.
// Issues column pairs, waits for the engine, writes both sums out.
module conv_scheduler #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = npu_pkg::K,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_src_base,
   input  logic [ADDR_W-1:0] i_kernel_base,
   input  logic [ADDR_W-1:0] i_out_base,
   input  logic [2:0]        i_stride,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_conv_start,
   output logic              o_conv_load_kernel,
   output logic [ADDR_W-1:0] o_conv_src_addr,
   output logic [ADDR_W-1:0] o_conv_kernel_addr,
   output logic [2:0]        o_conv_stride,
   input  logic              i_conv_done,
   input  logic [DATA_W-1:0] i_conv_sum1,
   input  logic [DATA_W-1:0] i_conv_sum2,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data
);
   import npu_pkg::*;

   localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam int CNT_W   = $clog2(MAX_DIM + 2);

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] src_base_q;
   logic [ADDR_W-1:0] kernel_base_q;
   logic [ADDR_W-1:0] out_base_q;
   logic [2:0]        stride_q;
   logic [DATA_W-1:0] sum1_q;
   logic [DATA_W-1:0] sum2_q;
   logic              first_q;
   logic              stride_ok;
   logic [CNT_W-1:0]  out_w;
   logic [CNT_W-1:0]  out_h;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] out_addr;
   logic              last_pair;
   logic              odd_tail;

   assign stride_ok = (stride_q != 3'd0) && (stride_q <= MAX_STRIDE);

   // Only four legal strides, so the output geometry is a constant lookup.
   always_comb begin
      out_w = '0;
      out_h = '0;
      case (stride_q)
         3'd1: begin
            out_w = CNT_W'((IMG_W - K) / 1 + 1);
            out_h = CNT_W'((IMG_H - K) / 1 + 1);
         end
         3'd2: begin
            out_w = CNT_W'((IMG_W - K) / 2 + 1);
            out_h = CNT_W'((IMG_H - K) / 2 + 1);
         end
         3'd3: begin
            out_w = CNT_W'((IMG_W - K) / 3 + 1);
            out_h = CNT_W'((IMG_H - K) / 3 + 1);
         end
         3'd4: begin
            out_w = CNT_W'((IMG_W - K) / 4 + 1);
            out_h = CNT_W'((IMG_H - K) / 4 + 1);
         end
         default: begin
            out_w = '0;
            out_h = '0;
         end
      endcase
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (i_start) state_n = CHECK;
         CHECK:   state_n = stride_ok ? ISSUE : IDLE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (i_conv_done) state_n = WR1;
         WR1:     state_n = odd_tail ? ADVANCE : WR2;
         WR2:     state_n = ADVANCE;
         ADVANCE: state_n = last_pair ? DONE : ISSUE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         src_base_q    <= '0;
         kernel_base_q <= '0;
         out_base_q    <= '0;
         stride_q      <= '0;
         sum1_q        <= '0;
         sum2_q        <= '0;
         first_q       <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && i_start) begin
            src_base_q    <= i_src_base;
            kernel_base_q <= i_kernel_base;
            out_base_q    <= i_out_base;
            stride_q      <= i_stride;
         end
         if (state == WAIT && i_conv_done) begin
            sum1_q <= i_conv_sum1;
            sum2_q <= i_conv_sum2;
         end
         if (state == CHECK) first_q <= 1'b1;
         else if (state == ISSUE) first_q <= 1'b0;
      end
   end

   conv_addr_gen #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_addr_gen (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .init      (state == CHECK && stride_ok),
      .advance   (state == ADVANCE),
      .src_base  (src_base_q),
      .out_base  (out_base_q),
      .stride    (stride_q),
      .out_w     (out_w),
      .out_h     (out_h),
      .src_addr  (src_addr),
      .out_addr  (out_addr),
      .last_pair (last_pair),
      .odd_tail  (odd_tail)
   );

   assign o_busy             = state inside {ISSUE, WAIT, WR1, WR2, ADVANCE};
   assign o_done             = (state == DONE);
   assign o_err              = (state == CHECK) && !stride_ok;
   assign o_conv_start       = (state == ISSUE);
   assign o_conv_load_kernel = (state == ISSUE) && first_q;
   assign o_conv_src_addr    = (state == ISSUE) ? src_addr : '0;
   assign o_conv_kernel_addr = kernel_base_q;
   assign o_conv_stride      = stride_q;
   assign o_wr_en            = (state == WR1) || (state == WR2);

   always_comb begin
      o_wr_addr = '0;
      o_wr_data = '0;
      if (state == WR1) begin
         o_wr_addr = out_addr;
         o_wr_data = sum1_q;
      end else if (state == WR2) begin
         o_wr_addr = out_addr + ADDR_W'(1);
         o_wr_data = sum2_q;
      end
   end

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler: emulated engine plus
// a position-walking reference model of the expected starts and writes.
module tb_conv_scheduler;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int AW    = 10;
   localparam int DW    = 8;

   logic          clk;
   logic          rst;
   logic          i_start;
   logic [AW-1:0] i_src_base;
   logic [AW-1:0] i_kernel_base;
   logic [AW-1:0] i_out_base;
   logic [2:0]    i_stride;
   logic          o_busy;
   logic          o_done;
   logic          o_err;
   logic          o_conv_start;
   logic          o_conv_load_kernel;
   logic [AW-1:0] o_conv_src_addr;
   logic [AW-1:0] o_conv_kernel_addr;
   logic [2:0]    o_conv_stride;
   logic          i_conv_done;
   logic [DW-1:0] i_conv_sum1;
   logic [DW-1:0] i_conv_sum2;
   logic          o_wr_en;
   logic [AW-1:0] o_wr_addr;
   logic [DW-1:0] o_wr_data;

   conv_scheduler #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .K      (3),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_start            (i_start),
      .i_src_base         (i_src_base),
      .i_kernel_base      (i_kernel_base),
      .i_out_base         (i_out_base),
      .i_stride           (i_stride),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_err              (o_err),
      .o_conv_start       (o_conv_start),
      .o_conv_load_kernel (o_conv_load_kernel),
      .o_conv_src_addr    (o_conv_src_addr),
      .o_conv_kernel_addr (o_conv_kernel_addr),
      .o_conv_stride      (o_conv_stride),
      .i_conv_done        (i_conv_done),
      .i_conv_sum1        (i_conv_sum1),
      .i_conv_sum2        (i_conv_sum2),
      .o_wr_en            (o_wr_en),
      .o_wr_addr          (o_wr_addr),
      .o_wr_data          (o_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          lk;
   } st_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   st_t exp_st[$];
   wr_t exp_wr[$];

   int checks     = 0;
   int failures   = 0;
   int dut_starts = 0;
   int dut_writes = 0;
   int done_cnt   = 0;
   int err_cnt    = 0;

   logic [AW-1:0] exp_kb;
   logic [2:0]    exp_s;
   bit            chk_cfg  = 0;
   int            lat_min  = 1;
   int            lat_max  = 1;
   bit            spurious = 0;

   function automatic logic [DW-1:0] f1(input logic [AW-1:0] a);
      int x;
      x = int'(a);
      return DW'(((x * 7) + 3) ^ (x >> 2));
   endfunction

   function automatic logic [DW-1:0] f2(input logic [AW-1:0] a);
      int x;
      x = int'(a);
      return DW'((x * 13) + 91);
   endfunction

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: walk every output position in raster order, two per pair.
   task automatic build_model(input int sb, input int ob, input int s);
      int  ow;
      int  oh;
      int  a;
      st_t st;
      wr_t w;
      exp_st.delete();
      exp_wr.delete();
      ow = (IMG_W - 3) / s + 1;
      oh = (IMG_H - 3) / s + 1;
      for (int r = 0; r < oh; r++) begin
         for (int c = 0; c < ow; c += 2) begin
            a       = (sb + r * s * IMG_W + c * s) % 1024;
            st.addr = AW'(a);
            st.lk   = (r == 0 && c == 0);
            exp_st.push_back(st);
            w.addr = AW'((ob + r * ow + c) % 1024);
            w.data = f1(AW'(a));
            exp_wr.push_back(w);
            if (c + 1 < ow) begin
               w.addr = AW'((ob + r * ow + c + 1) % 1024);
               w.data = f2(AW'(a));
               exp_wr.push_back(w);
            end
         end
      end
   endtask

   // Compare process
   always @(negedge clk) begin : cmp
      st_t st;
      wr_t w;
      if (!rst) begin
         if (o_conv_start) begin
            dut_starts++;
            if (exp_st.size() == 0) begin
               check_eq("start_extra", int'(o_conv_src_addr), -1);
            end else begin
               st = exp_st.pop_front();
               check_eq("start_src", int'(o_conv_src_addr), int'(st.addr));
               check_eq("start_lk", int'(o_conv_load_kernel), int'(st.lk));
            end
         end
         if (o_wr_en) begin
            dut_writes++;
            if (exp_wr.size() == 0) begin
               check_eq("write_extra", int'(o_wr_addr), -1);
            end else begin
               w = exp_wr.pop_front();
               check_eq("wr_addr", int'(o_wr_addr), int'(w.addr));
               check_eq("wr_data", int'(o_wr_data), int'(w.data));
            end
         end
         if (o_done) begin
            done_cnt++;
            check_eq("done_busy", int'(o_busy), 0);
         end
         if (o_err) err_cnt++;
         if (o_busy && chk_cfg) begin
            check_eq("cfg_kernel", int'(o_conv_kernel_addr), int'(exp_kb));
            check_eq("cfg_stride", int'(o_conv_stride), int'(exp_s));
         end
      end
   end

   // Emulated engine, with optional spurious done pulses outside WAIT
   initial begin : engine
      bit            pend;
      int            cnt;
      logic [AW-1:0] addr;
      pend        = 0;
      cnt         = 0;
      addr        = '0;
      i_conv_done = 1'b0;
      i_conv_sum1 = '0;
      i_conv_sum2 = '0;
      forever begin
         @(negedge clk);
         i_conv_done = 1'b0;
         i_conv_sum1 = '0;
         i_conv_sum2 = '0;
         if (rst) begin
            pend = 0;
         end else if (pend) begin
            if (cnt == 0) begin
               i_conv_done = 1'b1;
               i_conv_sum1 = f1(addr);
               i_conv_sum2 = f2(addr);
               pend        = 0;
            end else begin
               cnt--;
            end
         end else if (o_conv_start) begin
            pend = 1;
            addr = o_conv_src_addr;
            cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            if (spurious) begin
               i_conv_done = 1'b1;
               i_conv_sum1 = 8'hEE;
               i_conv_sum2 = 8'hDD;
            end
         end else if (o_wr_en && spurious) begin
            i_conv_done = 1'b1;
            i_conv_sum1 = 8'hAA;
            i_conv_sum2 = 8'h55;
         end
      end
   end

   task automatic start_job(input int sb, input int kb, input int ob, input int s);
      @(posedge clk);
      #1;
      i_src_base    = AW'(sb);
      i_kernel_base = AW'(kb);
      i_out_base    = AW'(ob);
      i_stride      = 3'(s);
      i_start       = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic legal_job(input int sb, input int kb, input int ob, input int s,
                            input int n_st, input int n_wr, input bit poke);
      int d0;
      int e0;
      int s0;
      int w0;
      bit poked;
      d0     = done_cnt;
      e0     = err_cnt;
      s0     = dut_starts;
      w0     = dut_writes;
      poked  = 0;
      exp_kb = AW'(kb);
      exp_s  = 3'(s);
      build_model(sb, ob, s);
      chk_cfg = 1;
      start_job(sb, kb, ob, s);
      for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
         @(posedge clk);
         #1;
         if (poke && !poked && dut_starts - s0 >= 10) begin
            i_src_base    = 10'd5;
            i_kernel_base = 10'd7;
            i_out_base    = 10'd9;
            i_stride      = 3'd1;
            i_start       = 1'b1;
            poked         = 1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_count", done_cnt - d0, 1);
      check_eq("err_in_job", err_cnt - e0, 0);
      check_eq("start_count", dut_starts - s0, n_st);
      check_eq("write_count", dut_writes - w0, n_wr);
      check_eq("starts_left", exp_st.size(), 0);
      check_eq("writes_left", exp_wr.size(), 0);
      check_eq("idle_after", int'(o_busy), 0);
      exp_st.delete();
      exp_wr.delete();
      chk_cfg = 0;
   endtask

   task automatic err_job(input int s);
      int d0;
      int e0;
      int s0;
      bit busy_seen;
      d0        = done_cnt;
      e0        = err_cnt;
      s0        = dut_starts;
      busy_seen = 0;
      start_job(3, 4, 5, s);
      repeat (6) begin
         @(negedge clk);
         if (o_busy) busy_seen = 1;
      end
      check_eq("err_pulse", err_cnt - e0, 1);
      check_eq("err_busy", int'(busy_seen), 0);
      check_eq("err_start", dut_starts - s0, 0);
      check_eq("err_done", done_cnt - d0, 0);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_ctl"}, int'({o_busy, o_done, o_err, o_conv_start,
                                    o_conv_load_kernel, o_wr_en}), 0);
      check_eq({tag, "_src"}, int'(o_conv_src_addr), 0);
      check_eq({tag, "_kern"}, int'(o_conv_kernel_addr), 0);
      check_eq({tag, "_strd"}, int'(o_conv_stride), 0);
      check_eq({tag, "_wa"}, int'(o_wr_addr), 0);
      check_eq({tag, "_wd"}, int'(o_wr_data), 0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int d0;
      int e0;
      int s0;
      rst           = 1'b1;
      i_start       = 1'b0;
      i_src_base    = '0;
      i_kernel_base = '0;
      i_out_base    = '0;
      i_stride      = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Model pins for stride 1 and stride 2 geometry
      build_model(1008, 512, 1);
      check_eq("model_s1_starts", exp_st.size(), 338);
      check_eq("model_s1_writes", exp_wr.size(), 676);
      check_eq("model_s1_last", int'(exp_wr[675].addr), (512 + 675) % 1024);
      build_model(100, 300, 2);
      check_eq("model_s2_starts", exp_st.size(), 91);
      check_eq("model_s2_writes", exp_wr.size(), 169);
      check_eq("model_s2_pair06", int'(exp_st[3].addr), 112);
      check_eq("model_s2_tail", int'(exp_wr[12].addr), 312);
      check_eq("model_s2_row1", int'(exp_wr[13].addr), 313);

      // Stride 1 full map, address wrap on both source and output
      legal_job(1008, 21, 512, 1, 338, 676, 0);
      // Stride 2, odd output width
      legal_job(100, 40, 300, 2, 91, 169, 0);
      // Illegal strides
      err_job(0);
      err_job(5);
      // Random engine latency with spurious done pulses
      lat_min  = 1;
      lat_max  = 20;
      spurious = 1;
      legal_job(37, 600, 10, 1, 338, 676, 0);
      legal_job(0, 1, 2, 4, 28, 49, 0);
      spurious = 0;

      // Reset during WAIT of pair 50
      lat_min = 20;
      lat_max = 20;
      exp_kb  = 10'd33;
      exp_s   = 3'd1;
      build_model(200, 400, 1);
      chk_cfg = 1;
      d0      = done_cnt;
      e0      = err_cnt;
      s0      = dut_starts;
      start_job(200, 33, 400, 1);
      for (int i = 0; i < 5000 && dut_starts - s0 < 51; i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("reached_pair50", dut_starts - s0, 51);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_zero("midrst");
      chk_cfg = 0;
      exp_st.delete();
      exp_wr.delete();
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_no_done", done_cnt - d0, 0);
      check_eq("rst_no_err", err_cnt - e0, 0);
      lat_min = 1;
      lat_max = 3;
      legal_job(50, 60, 70, 2, 91, 169, 0);

      // Start pulsed mid-job with changed config
      legal_job(900, 123, 800, 3, 45, 81, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
